alu_ex_stage: RTL and testbench
===============================

// Module: alu_ex_stage
// PURPOSE
// - Execute stage of the RV32I integer pipeline: consumes decoded operands from decode, computes the ALU result, registers it for memory/writeback.
// - Single-entry output register with valid/ready handshake on both sides; 1-cycle latency.
// - All add/sub/compare arithmetic goes through one instance of the existing ripple adder `add`.
// PARAMETERS
// - XLEN   32   datapath width in bits; shift amount width is $clog2(XLEN)
// - RegAw  5    destination register index width
// PORTS
// - clk         in   1      clock
// - rst_n       in   1      reset, synchronous, active-low
// - flush       in   1      kill the held result and drop any accept this cycle (branch redirect)
// - in_valid    in   1      decode presents an operation
// - in_ready    out  1      stage can accept this cycle
// - in_op       in   4      ALU op {funct7[5], funct3} per riscv_pkg::alu_op_e
// - in_a        in   XLEN   operand A (rs1 or PC)
// - in_b        in   XLEN   operand B (rs2 or immediate)
// - in_rd       in   RegAw  destination register index
// - out_valid   out  1      registered result is valid
// - out_ready   in   1      downstream accepts the result
// - out_result  out  XLEN   registered ALU result
// - out_rd      out  RegAw  registered destination index
// BEHAVIOUR
// - Reset (rst_n==0 at posedge): out_valid=0, out_result=0, out_rd=0. in_ready follows its equation.
// - in_ready = !out_valid || out_ready (combinational; no ready->ready loop to decode).
// - Accept = in_valid && in_ready && !flush. On accept: out_result/out_rd load next edge, out_valid=1.
// - Drain: out_valid && out_ready && !accept -> out_valid=0 next edge; out_result/out_rd hold.
// - Simultaneous drain and accept: new result replaces old and out_valid stays 1. Back-to-back throughput is 1/cycle.
// - Stall: out_valid && !out_ready -> out_result/out_rd stable, in_ready=0.
// - flush=1: out_valid=0 next edge regardless of in_valid/out_ready. Data regs may hold stale values.
// - Reset and flush both beat accept. Reset also beats flush.
// - Ops (wrap-around modulo 2^XLEN, no traps):
//   - ADD 0000: a+b via add(cin=0).
//   - SUB 1000: a+~b via add(cin=1).
//   - SLL 0001: a << b[4:0].
//   - SLT 0010: signed a<b, computed as sub sign XOR signed overflow; result is 0/1 zero-extended.
//   - SLTU 0011: !cout of the sub.
//   - XOR 0100.
//   - SRL 0101: logical.
//   - SRA 1101: arithmetic; sign fills.
//   - OR 0110.
//   - AND 0111.
// - Undefined op codes yield result 0 but are otherwise accepted normally.
// - SLT/SLTU/SUB share the single adder: its b input is ~b and cin=1 for those ops, else b and cin=0.
// - Shift amount is b[$clog2(XLEN)-1:0]; upper bits of b are ignored.
// - rd==0 is not special-cased here; writeback discards x0 writes.
// STRUCTURE
// - riscv_pkg:
//   - typedef enum logic [3:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND}.
//   - localparam XLEN = 32.
// - Sub-module: add #(.BitWidth(XLEN)); exactly one instance.
// - Remaining logic: combinational op mux, one output register bank, the handshake equations.
// TESTING
// - Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_result=0, out_rd=0; first accept on the cycle after rst_n=1.
// - Arithmetic:
//   - ADD 0xFFFFFFFF+1 -> 0x00000000 (wrap).
//   - SUB 5-7 -> 0xFFFFFFFE.
//   - SLT 0x80000000 vs 1 -> 1.
//   - SLTU 0x80000000 vs 1 -> 0.
// - Shifts:
//   - SRA 0x80000000 by b=0x21 -> 0xC0000000 (only b[4:0]=1 used).
//   - SRL same operands -> 0x40000000.
//   - SLL 1 by 31 -> 0x80000000.
// - Backpressure:
//   - out_ready=0 for 3 cycles while holding result 0x1234 -> out_result stable, in_ready=0.
//   - out_ready=1 with in_valid=1 -> next result loaded the same edge; out_valid never drops.
// - Flush:
//   - flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle and the input is not captured.
//   - Flush during stall also clears out_valid.
// - Streaming: 16 back-to-back ADDs a=i, b=i, out_ready=1 -> 16 results 2*i in order, one per cycle, rd tagged i.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width and the ALU operation encoding
// ({funct7[5], funct3}) used by decode and the execute stage.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int REGAW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  // True for ops that route through the adder in subtract mode.
  function automatic logic uses_sub(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/add.sv
// Ripple-carry adder with carry in/out; the single shared arithmetic unit of the
// execute stage (add, subtract and both compares).
module add #(
  parameter int BitWidth = 32
) (
  input  logic [BitWidth-1:0] a,
  input  logic [BitWidth-1:0] b,
  input  logic                cin,
  output logic [BitWidth-1:0] sum,
  output logic                cout
);

  logic carry;

  // NOTE: blocking assignments are correct here: the carry variable is a
  // combinational temporary that must ripple bit by bit within one evaluation.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < BitWidth; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/alu_ex_stage.sv
// RV32I execute stage: combinational ALU feeding a single-entry output register
// with valid/ready handshakes on both sides (1-cycle latency, 1/cycle throughput).
module alu_ex_stage #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int RegAw = riscv_pkg::REGAW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [RegAw-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [RegAw-1:0] out_rd
);

  import riscv_pkg::*;

  localparam int ShW = $clog2(XLEN);

  logic            sub_mode;
  logic [XLEN-1:0] add_b;
  logic [XLEN-1:0] add_sum;
  logic            add_cout;
  logic            signed_ovf;
  logic            slt_bit;
  logic            sltu_bit;
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] alu_result;
  logic            accept;

  // Subtract-type ops feed ~b with cin=1 so a single adder covers a+b and a-b.
  assign sub_mode = uses_sub(in_op);
  assign add_b    = sub_mode ? ~in_b : in_b;

  add #(.BitWidth(XLEN)) u_add (
    .a    (in_a),
    .b    (add_b),
    .cin  (sub_mode),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // a-b overflows when operand signs differ and the difference sign differs from a.
  assign signed_ovf = (in_a[XLEN-1] ^ in_b[XLEN-1]) & (add_sum[XLEN-1] ^ in_a[XLEN-1]);
  assign slt_bit    = add_sum[XLEN-1] ^ signed_ovf;
  assign sltu_bit   = ~add_cout;
  assign shamt      = in_b[ShW-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    alu_result = '0;
    case (in_op)
      ALU_ADD,
      ALU_SUB:  alu_result = add_sum;
      ALU_SLL:  alu_result = in_a << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, slt_bit};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, sltu_bit};
      ALU_XOR:  alu_result = in_a ^ in_b;
      ALU_SRL:  alu_result = in_a >> shamt;
      ALU_SRA:  alu_result = $signed(in_a) >>> shamt;
      ALU_OR:   alu_result = in_a | in_b;
      ALU_AND:  alu_result = in_a & in_b;
      default:  alu_result = '0;
    endcase
  end

  // Ready depends only on local state and out_ready, never on in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Data only moves on accept; a flush leaves stale but harmless values.
      if (accept) begin
        out_result <= alu_result;
        out_rd     <= in_rd;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed corner cases, then a
// randomized phase scored against a transaction-level reference model.
module tb_alu_ex_stage;

  import riscv_pkg::*;

  localparam int W  = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [RW-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [RW-1:0] out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0]  result;
    logic [RW-1:0] rd;
  } txn_t;

  txn_t exp_q[$];

  always #5 clk = ~clk;

  alu_ex_stage #(.XLEN(W), .RegAw(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned sh;
    sh = b % W;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return W'($signed(a) >>> sh);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [RW-1:0] rd);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted op with an immediate drain downstream; checks the registered result.
  task automatic op_check(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
    drive(1'b1, op, a, b, 5'd7);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_result, exp);
  endtask

  initial begin
    logic rdy;
    txn_t t;

    // Reset with a valid input waiting: nothing may be captured.
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, ALU_ADD, 32'd1, 32'd2, 5'd3);
    repeat (2) begin
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_rd", out_rd, 0);
    end
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    check("first_accept_valid", out_valid, 1);
    check("first_accept_result", out_result, 32'd3);
    check("first_accept_rd", out_rd, 3);

    // Arithmetic and shift corners.
    op_check("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
    op_check("sub_neg", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    op_check("slt_signed", ALU_SLT, 32'h8000_0000, 32'd1, 32'd1);
    op_check("sltu_unsigned", ALU_SLTU, 32'h8000_0000, 32'd1, 32'd0);
    op_check("slt_ovf", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
    op_check("sra_fill", ALU_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000);
    op_check("srl_zero", ALU_SRL, 32'h8000_0000, 32'h21, 32'h4000_0000);
    op_check("sll_31", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000);
    op_check("xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
    op_check("or", ALU_OR, 32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011);
    op_check("and", ALU_AND, 32'hF0F0_FFFF, 32'h0FF0_1234, 32'h00F0_1234);
    op_check("undef_op", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    check("rd_tag", out_rd, 7);

    // Backpressure: hold 0x1234 for three stalled cycles.
    op_check("bp_load", ALU_ADD, 32'h1000, 32'h234, 32'h1234);
    out_ready = 1'b0;
    drive(1'b1, ALU_ADD, 32'd5, 32'd5, 5'd9);
    repeat (3) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 32'h1234);
      check("bp_rd", out_rd, 7);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_replace_valid", out_valid, 1);
    check("bp_replace_result", out_result, 32'd10);
    check("bp_replace_rd", out_rd, 9);
    drive(1'b1, ALU_ADD, 32'd6, 32'd6, 5'd10);
    tick();
    check("b2b_valid", out_valid, 1);
    check("b2b_result", out_result, 32'd12);

    // Flush with a held result and a valid input: both dropped.
    flush     = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, ALU_ADD, 32'd7, 32'd7, 5'd11);
    tick();
    check("flush_valid", out_valid, 0);
    flush = 1'b0;
    drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
    tick();
    check("flush_no_capture_valid", out_valid, 0);
    check("flush_no_capture_result", out_result, 32'd12);
    check("flush_no_capture_rd", out_rd, 10);

    // Flush during a stall.
    drive(1'b1, ALU_ADD, 32'd2, 32'd3, 5'd4);
    tick();
    check("stall_load", out_result, 32'd5);
    drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
    tick();
    check("stall_hold_valid", out_valid, 1);
    flush = 1'b1;
    tick();
    check("stall_flush_valid", out_valid, 0);
    flush     = 1'b0;
    out_ready = 1'b1;

    // Streaming: 16 back-to-back ADDs.
    drive(1'b1, ALU_ADD, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 15) drive(1'b1, ALU_ADD, W'(i + 1), W'(i + 1), RW'(i + 1));
      else drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
      check("stream_valid", out_valid, 1);
      check("stream_result", out_result, W'(2 * i));
      check("stream_rd", out_rd, W'(i));
    end
    tick();
    check("stream_drained", out_valid, 0);

    // Randomized traffic scored against a one-deep transaction queue.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 40)),
            RW'($urandom_range(0, 31)));
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 19) == 0;
      #1;
      rdy = (exp_q.size() == 0) || out_ready;
      check("rnd_out_valid", out_valid, W'(exp_q.size() != 0));
      check("rnd_in_ready", in_ready, W'(rdy));
      if (exp_q.size() != 0) begin
        check("rnd_result", out_result, exp_q[0].result);
        check("rnd_rd", out_rd, W'(exp_q[0].rd));
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && rdy) begin
          t.result = ref_alu(in_op, in_a, in_b);
          t.rd     = in_rd;
          exp_q.push_back(t);
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
